// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment display controller with a small CPU-writable
// register window (data, digit-enable and decimal-point masks).
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_cs,
  input  logic        io_write,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic [7:0]  DIG,
  output logic [7:0]  Y
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [15:0]      data_lo_q, data_lo_d;
  logic [15:0]      data_hi_q, data_hi_d;
  logic [7:0]       en_mask_q, en_mask_d;
  logic [7:0]       dp_mask_q, dp_mask_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dig_q, dig_d;
  logic [7:0]       y_q, y_d;

  logic        wr_en;
  logic        tc;
  logic [31:0] disp_data;
  logic [3:0]  nibble;
  logic [6:0]  seg_code;

  always_comb begin
    unique case (nibble)
      4'h0: seg_code = 7'h40;
      4'h1: seg_code = 7'h79;
      4'h2: seg_code = 7'h24;
      4'h3: seg_code = 7'h30;
      4'h4: seg_code = 7'h19;
      4'h5: seg_code = 7'h12;
      4'h6: seg_code = 7'h02;
      4'h7: seg_code = 7'h78;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h10;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h03;
      4'hC: seg_code = 7'h46;
      4'hD: seg_code = 7'h21;
      4'hE: seg_code = 7'h06;
      default: seg_code = 7'h0E;
    endcase
  end

  always_comb begin
    data_lo_d = data_lo_q;
    data_hi_d = data_hi_q;
    en_mask_d = en_mask_q;
    dp_mask_d = dp_mask_q;
    wr_en     = seg_cs & io_write;
    if (wr_en) begin
      case (addr)
        3'd0: data_lo_d = wdata;
        3'd2: data_hi_d = wdata;
        3'd4: begin
          en_mask_d = wdata[7:0];
          dp_mask_d = wdata[15:8];
        end
        default: ;
      endcase
    end

    // Scan timing is independent of register writes.
    tc    = (div_q == DIV_LAST);
    div_d = tc ? '0 : div_q + DIV_W'(1);
    idx_d = tc ? idx_q + 3'd1 : idx_q;

    // Outputs are built from the current slot and register contents, giving one
    // cycle of latency from any write or slot change to the pins.
    disp_data = {data_hi_q, data_lo_q};
    nibble    = disp_data[{idx_q, 2'b00} +: 4];
    dig_d     = 8'hFF;
    y_d       = 8'hFF;
    if (en_mask_q[idx_q]) begin
      dig_d = ~(8'd1 << idx_q);
      y_d   = {~dp_mask_q[idx_q], seg_code};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_lo_q <= '0;
      data_hi_q <= '0;
      en_mask_q <= 8'hFF;
      dp_mask_q <= 8'h00;
      div_q     <= '0;
      idx_q     <= '0;
      dig_q     <= 8'hFF;
      y_q       <= 8'hFF;
    end else begin
      data_lo_q <= data_lo_d;
      data_hi_q <= data_hi_d;
      en_mask_q <= en_mask_d;
      dp_mask_q <= dp_mask_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      dig_q     <= dig_d;
      y_q       <= y_d;
    end
  end

  assign DIG = dig_q;
  assign Y   = y_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-count model predicts DIG/Y per edge,
// a negedge monitor pops and compares.
module tb_seg7_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seg_cs = 1'b0;
  logic        io_write = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [7:0]  DIG;
  logic [7:0]  Y;

  seg7_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .seg_cs(seg_cs), .io_write(io_write),
    .addr(addr), .wdata(wdata), .DIG(DIG), .Y(Y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: display contents and the number of clock edges since reset release.
  logic [31:0] m_data;
  logic [7:0]  m_en, m_dp;
  int          m_cnt;
  logic [15:0] exp_q [$];

  initial begin
    m_data = '0; m_en = 8'hFF; m_dp = 8'h00; m_cnt = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_data = '0; m_en = 8'hFF; m_dp = 8'h00; m_cnt = 0;
        exp_q.delete();
      end else begin
        int   slot;
        logic [7:0] e_dig, e_y;
        slot = (m_cnt / DIV) % 8;
        if (m_en[slot]) begin
          e_dig = 8'hFF;
          e_dig[slot] = 1'b0;
          e_y = {~m_dp[slot], seg_tab[(m_data >> (4 * slot)) & 32'hF]};
        end else begin
          e_dig = 8'hFF;
          e_y   = 8'hFF;
        end
        exp_q.push_back({e_dig, e_y});
        if (seg_cs && io_write) begin
          if (addr == 3'd0) m_data[15:0] = wdata;
          else if (addr == 3'd2) m_data[31:16] = wdata;
          else if (addr == 3'd4) begin
            m_en = wdata[7:0];
            m_dp = wdata[15:8];
          end
        end
        m_cnt++;
      end
    end
  end

  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      if (rst && exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({DIG, Y} !== e) begin
          errors++;
          $display("FAIL out[%0d] DIG=%h Y=%h expected DIG=%h Y=%h", n, DIG, Y, e[15:8], e[7:0]);
        end else begin
          $display("out[%0d] DIG=%h Y=%h ok", n, DIG, Y);
        end
        checks++;
        if ($countones(~DIG) > 1) begin
          errors++;
          $display("FAIL onehot[%0d] DIG=%h expected at most one low bit", n, DIG);
        end
        n++;
      end
    end
  end

  task automatic wr(input logic cs, input logic we, input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    seg_cs = cs; io_write = we; addr = a; wdata = d;
    @(negedge clk);
    seg_cs = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic check_rst_out(input string name);
    checks++;
    if (DIG !== 8'hFF || Y !== 8'hFF) begin
      errors++;
      $display("FAIL %s DIG=%h Y=%h expected DIG=ff Y=ff", name, DIG, Y);
    end else begin
      $display("%s DIG=%h Y=%h ok", name, DIG, Y);
    end
  endtask

  initial begin
    int guard;
    #12;
    check_rst_out("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    repeat (40) @(negedge clk);

    wr(1'b1, 1'b1, 3'd0, 16'h3210);
    wr(1'b1, 1'b1, 3'd2, 16'h7654);
    repeat (36) @(negedge clk);

    wr(1'b1, 1'b1, 3'd4, 16'h0105);
    repeat (36) @(negedge clk);

    wr(1'b0, 1'b1, 3'd0, 16'hABCD);
    wr(1'b1, 1'b0, 3'd2, 16'h1234);
    wr(1'b1, 1'b1, 3'd1, 16'h5555);
    wr(1'b1, 1'b1, 3'd6, 16'h00F0);
    wr(1'b1, 1'b1, 3'd3, 16'hFFFF);
    repeat (36) @(negedge clk);

    // Asynchronous reset pulse in the middle of the idx=5 slot.
    wr(1'b1, 1'b1, 3'd4, 16'hA5FF);
    guard = 0;
    while (((m_cnt / DIV) % 8) != 5 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL wait_idx5 cycles=%0d required <64", guard);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_rst_out("async_reset");
    #2 rst = 1'b1;

    // Write on the terminal-count edge of slot 0 (4th edge after release).
    repeat (3) @(posedge clk);
    wr(1'b1, 1'b1, 3'd0, 16'hFFFF);
    repeat (34) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) begin
        logic [2:0] a;
        a = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = 3'($urandom_range(0, 2) * 2);
        wr(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0), a, 16'($urandom));
      end else begin
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t required finish before 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
